// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter for the shared memory/peripheral port with programmable wait cycles.
// Define ARB_FIXED_PRIO_EN for fixed CPU priority; the default build is round-robin.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int WAIT_CYC = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dma;
    logic       pick_dma;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick_dma = dma_req && !cpu_req;
    end
`else
    logic prio_dma;

    // prio_dma is set after the CPU was served, so a contended cycle goes to the other side
    always_comb begin
        pick_dma = dma_req && (!cpu_req || prio_dma);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_dma <= 1'b0;
            grant     <= '0;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
            prio_dma  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner_dma <= pick_dma;
                        grant     <= pick_dma ? 2'b10 : 2'b01;
                        mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
                        mem_write <= pick_dma ? dma_we    : cpu_we;
                        mem_en    <= 1'b1;
                        cnt       <= 4'(WAIT_CYC);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // mem_write doubles as the latched direction for the whole access
                        if (!mem_write) begin
                            if (owner_dma) dma_rdata <= mem_rdata;
                            else           cpu_rdata <= mem_rdata;
                        end
                        if (owner_dma) dma_ack <= 1'b1;
                        else           cpu_ack <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    cpu_ack  <= 1'b0;
                    dma_ack  <= 1'b0;
                    grant    <= '0;
`ifndef ARB_FIXED_PRIO_EN
                    prio_dma <= !owner_dma;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_bus_arbiter;

    localparam int W = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0;
    logic [63:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;

    logic        cpu_ack, dma_ack, mem_en, mem_write;
    logic [63:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [1:0]  grant;

    logic        cpu_ack_0, dma_ack_0, mem_en_0, mem_write_0;
    logic [63:0] cpu_rdata_0, dma_rdata_0, mem_wdata_0;
    logic [15:0] mem_addr_0;
    logic [1:0]  grant_0;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(64), .WAIT_CYC(W)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(64), .WAIT_CYC(0)) u_w0 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_0), .cpu_rdata(cpu_rdata_0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack_0), .dma_rdata(dma_rdata_0),
        .mem_en(mem_en_0), .mem_write(mem_write_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
        .mem_rdata(mem_rdata), .grant(grant_0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: owner (0 none, 1 CPU, 2 DMA) and age = cycles since the access was granted.
    int          m_owner = 0;
    int          m_age = 0;
    bit          m_fav_dma = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [63:0] m_wdata = '0, m_cpu_rdata = '0, m_dma_rdata = '0;

    always @(posedge clock) begin
        int w;
        if (reset) begin
            m_owner = 0; m_age = 0; m_fav_dma = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_cpu_rdata = '0; m_dma_rdata = '0;
        end else if (m_owner == 0) begin
            if (cpu_req || dma_req) begin
`ifdef ARB_FIXED_PRIO_EN
                w = cpu_req ? 1 : 2;
`else
                if (cpu_req && dma_req) w = m_fav_dma ? 2 : 1;
                else                    w = cpu_req ? 1 : 2;
`endif
                m_owner = w;
                m_age   = 0;
                m_we    = (w == 1) ? cpu_we : dma_we;
                m_addr  = (w == 1) ? cpu_addr : dma_addr;
                m_wdata = (w == 1) ? cpu_wdata : dma_wdata;
            end
        end else begin
            m_age++;
            if (m_age == W + 1 && !m_we) begin
                if (m_owner == 1) m_cpu_rdata = mem_rdata;
                else              m_dma_rdata = mem_rdata;
            end else if (m_age == W + 2) begin
                m_fav_dma = (m_owner == 1);
                m_owner   = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic       e_en;
        logic [1:0] e_grant;
        if (chk_on) begin
            e_en    = (m_owner != 0) && (m_age <= W);
            e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            check("mdl_grant", 64'(grant), 64'(e_grant));
            check("mdl_mem_en", 64'(mem_en), 64'(e_en));
            check("mdl_mem_write", 64'(mem_write), 64'(e_en && m_we));
            check("mdl_mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mdl_mem_wdata", mem_wdata, m_wdata);
            check("mdl_cpu_ack", 64'(cpu_ack), 64'(m_owner == 1 && m_age == W + 1));
            check("mdl_dma_ack", 64'(dma_ack), 64'(m_owner == 2 && m_age == W + 1));
            check("mdl_cpu_rdata", cpu_rdata, m_cpu_rdata);
            check("mdl_dma_rdata", dma_rdata, m_dma_rdata);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n_acks;
        int first_c;
        int last_c;
        int dma_cnt;
        int who[4];
        int exp_who[4];

        repeat (2) tick();
        chk_on = 1'b1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_mem_en", 64'(mem_en), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_cpu_rdata", cpu_rdata, 64'h0);
        reset = 1'b0;

        // Single CPU read: ack three edges after the IDLE cycle begins
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; mem_rdata = 64'hDEADBEEF00000001;
        tick();
        check("rd_en_c1", 64'(mem_en), 64'h1);
        check("rd_grant", 64'(grant), 64'h1);
        tick();
        check("rd_en_c2", 64'(mem_en), 64'h1);
        check("rd_ack_early", 64'(cpu_ack), 64'h0);
        tick();
        check("rd_ack", 64'(cpu_ack), 64'h1);
        check("rd_en_done", 64'(mem_en), 64'h0);
        check("rd_rdata", cpu_rdata, 64'hDEADBEEF00000001);
        check("rd_dma_ack", 64'(dma_ack), 64'h0);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_off", 64'(cpu_ack), 64'h0);
        repeat (3) tick();

        // DMA write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 64'h1234;
        for (int c = 1; c <= W + 1; c++) begin
            tick();
            check("wr_mem_write", 64'(mem_write), 64'h1);
            check("wr_mem_addr", 64'(mem_addr), 64'h0200);
            check("wr_mem_wdata", mem_wdata, 64'h1234);
        end
        tick();
        check("wr_dma_ack", 64'(dma_ack), 64'h1);
        check("wr_dma_rdata", dma_rdata, 64'h0);
        dma_req = 1'b0; dma_we = 1'b0;
        repeat (4) tick();

        // Both requesting continuously for four accesses
        cpu_req = 1'b1; dma_req = 1'b1; mem_rdata = 64'hA5A5A5A5_5A5A5A5A;
        n_acks = 0; first_c = 0; last_c = 0; dma_cnt = 0;
        for (int c = 1; c <= 40 && n_acks < 4; c++) begin
            tick();
            if (cpu_ack || dma_ack) begin
                check("rr_one_ack", 64'(cpu_ack && dma_ack), 64'h0);
                who[n_acks] = dma_ack ? 2 : 1;
                if (dma_ack) dma_cnt++;
                if (n_acks == 0) first_c = c;
                else check("rr_spacing", 64'(c - last_c), 64'(W + 3));
                last_c = c;
                n_acks++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("rr_ack_count", 64'(n_acks), 64'd4);
        check("rr_first_ack", 64'(first_c), 64'(W + 2));
`ifdef ARB_FIXED_PRIO_EN
        exp_who = '{1, 1, 1, 1};
        check("fp_dma_acks", 64'(dma_cnt), 64'd0);
`else
        exp_who = '{1, 2, 1, 2};
        check("rr_dma_acks", 64'(dma_cnt), 64'd2);
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < n_acks) check("rr_owner", 64'(who[i]), 64'(exp_who[i]));
        end
        repeat (6) tick();

        // Reset during the second BUSY cycle aborts the CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300; mem_rdata = 64'h1111;
        tick();
        tick();
        check("ab_in_busy", 64'(mem_en), 64'h1);
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        check("ab_mem_en", 64'(mem_en), 64'h0);
        check("ab_grant", 64'(grant), 64'h0);
        check("ab_cpu_ack", 64'(cpu_ack), 64'h0);
        check("ab_cpu_rdata", cpu_rdata, 64'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Zero wait cycles; CPU drops req during BUSY
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; mem_rdata = 64'h0BADF00D;
        tick();
        check("w0_busy", 64'(mem_en_0), 64'h1);
        cpu_req = 1'b0;
        tick();
        check("w0_ack", 64'(cpu_ack_0), 64'h1);
        check("w0_rdata", cpu_rdata_0, 64'h0BADF00D);
        tick();
        check("w0_ack_off", 64'(cpu_ack_0), 64'h0);
        check("w0_grant", 64'(grant_0), 64'h0);
        tick();
        check("w0_no_second", 64'(mem_en_0), 64'h0);
        check("w0_idle_grant", 64'(grant_0), 64'h0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
